// File: rtl/mem_resp_port.sv
// Multi-cycle byte/half/word memory port with a fixed wait latency and a one-cycle response pulse.
// Define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of forcing the low address bits to zero.
module mem_resp_port #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_req,
  input  logic        MEM_write,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  Size,
  output logic [31:0] MEM_out,
  output logic        MEM_ready,
  output logic        MEM_busy,
  output logic        Align_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        fault_q;
  logic [31:0] out_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [31:0]   rdata;
  logic [31:0]   wword;
  logic [3:0]    lane_en;
  logic          fault;
  logic          unused_addr;

  assign idx         = addr_q[AW+1:2];
  assign unused_addr = ^addr_q[31:AW+2];
  assign rword       = mem[idx];

  // Store data is replicated across lanes so the lane enables alone pick what lands.
  always_comb begin
    fault   = 1'b0;
    lane_en = 4'b0000;
    wword   = wdata_q;
    rdata   = 32'd0;
    case (size_q)
      2'b00: begin
        lane_en = 4'b0001 << addr_q[1:0];
        wword   = {4{wdata_q[7:0]}};
        rdata   = {24'd0, rword[{addr_q[1:0], 3'b000} +: 8]};
      end
      2'b01: begin
`ifdef MEM_ALIGN_CHECK_EN
        fault   = addr_q[0];
`endif
        lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata_q[15:0]}};
        rdata   = {16'd0, rword[{addr_q[1], 4'b0000} +: 16]};
      end
      2'b10: begin
`ifdef MEM_ALIGN_CHECK_EN
        fault   = |addr_q[1:0];
`endif
        lane_en = 4'b1111;
        rdata   = rword;
      end
      default: fault = 1'b1;
    endcase
    if (fault) begin
      lane_en = 4'b0000;
      rdata   = 32'd0;
    end
  end

  // Backing store is never cleared; a reset landing on the ACCESS edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      fault_q <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_req) begin
            write_q <= MEM_write;
            addr_q  <= Addr;
            wdata_q <= WData;
            size_q  <= Size;
            cnt     <= LAT_M1;
            state   <= (LATENCY == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          fault_q <= fault;
          out_q   <= write_q ? 32'd0 : rdata;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MEM_out   = out_q;
  assign MEM_ready = (state == RESP);
  assign MEM_busy  = (state != IDLE);
  assign Align_err = (state == RESP) && fault_q;

endmodule

// File: tb/tb_mem_resp_port.sv
// Randomized self-checking bench for mem_resp_port against an array-based memory model.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_resp_port;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        MEM_req;
  logic        MEM_write;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [1:0]  Size;
  logic [31:0] MEM_out;
  logic        MEM_ready;
  logic        MEM_busy;
  logic        Align_err;

  int errCount   = 0;
  int checkCount = 0;

  logic [31:0] modelMem [DEPTH];

  mem_resp_port #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .MEM_req   (MEM_req),
    .MEM_write (MEM_write),
    .Addr      (Addr),
    .WData     (WData),
    .Size      (Size),
    .MEM_out   (MEM_out),
    .MEM_ready (MEM_ready),
    .MEM_busy  (MEM_busy),
    .Align_err (Align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic modelFault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int modelShift(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 8 * int'(a % 4);
    if (sz == 2'd1) return 16 * int'((a % 4) / 2);
    return 0;
  endfunction

  function automatic logic [31:0] modelMask(input logic [1:0] sz);
    if (sz == 2'd0) return 32'h0000_00FF;
    if (sz == 2'd1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int modelIndex(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Drives one request, scrambles the inputs after acceptance and waits (bounded) for the response.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] sz, output logic [31:0] out, output logic err,
                               output int lat);
    @(negedge clk);
    MEM_req   = 1'b1;
    MEM_write = wr;
    Addr      = a;
    WData     = wd;
    Size      = sz;
    @(posedge clk);
    @(negedge clk);
    MEM_req   = 1'b0;
    MEM_write = ~wr;
    Addr      = $urandom;
    WData     = $urandom;
    Size      = 2'($urandom);
    lat = 1;
    while (!MEM_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    out = MEM_out;
    err = Align_err;
  endtask

  task automatic runTxn(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] expOut;
    logic        expErr;
    logic [31:0] out;
    logic        err;
    int          lat;
    int          idx;
    int          sh;
    logic [31:0] m;
    expErr = modelFault(sz, a);
    idx    = modelIndex(a);
    sh     = modelShift(sz, a);
    m      = modelMask(sz);
    if (wr || expErr) expOut = 32'd0;
    else expOut = (modelMem[idx] >> sh) & m;
    applyStimulus(wr, a, wd, sz, out, err, lat);
    checkOutput({tag, " latency"}, lat, LATENCY + 2);
    checkOutput({tag, " MEM_out"}, out, expOut);
    checkOutput({tag, " Align_err"}, {31'd0, err}, {31'd0, expErr});
    @(negedge clk);
    checkOutput({tag, " ready_pulse"}, {31'd0, MEM_ready}, 32'd0);
    checkOutput({tag, " idle_busy"}, {31'd0, MEM_busy}, 32'd0);
    checkOutput({tag, " MEM_out_hold"}, MEM_out, expOut);
    if (wr && !expErr) begin
      modelMem[idx] = (modelMem[idx] & ~(m << sh)) | ((wd & m) << sh);
    end
  endtask

  initial begin
    logic [31:0] dout;
    logic        derr;
    int          dlat;
    int          nReady;
    int          firstAt;
    int          secondAt;
    int          abortAt [2];

    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'd0;
    reset     = 1'b1;
    MEM_req   = 1'b0;
    MEM_write = 1'b0;
    Addr      = 32'd0;
    WData     = 32'd0;
    Size      = 2'b10;

    // Reset holds everything quiet even with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    MEM_req = 1'b1;
    @(negedge clk);
    checkOutput("reset MEM_out", MEM_out, 32'd0);
    checkOutput("reset MEM_busy", {31'd0, MEM_busy}, 32'd0);
    checkOutput("reset MEM_ready", {31'd0, MEM_ready}, 32'd0);
    checkOutput("reset Align_err", {31'd0, Align_err}, 32'd0);
    MEM_req = 1'b0;
    reset   = 1'b0;

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i * 4), 32'd0, 2'b10, dout, derr, dlat);
    @(negedge clk);

    $display("[TB] directed tests");
    runTxn("t1 wr", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10);
    runTxn("t1 rd", 1'b0, 32'h10, 32'h0, 2'b10);

    runTxn("t2 init", 1'b1, 32'h10, 32'h11223344, 2'b10);
    runTxn("t2 bwr", 1'b1, 32'h13, 32'hFFFF_FFAA, 2'b00);
    runTxn("t2 wrd", 1'b0, 32'h10, 32'h0, 2'b10);
    checkOutput("t2 word value", modelMem[4], 32'hAA223344);
    runTxn("t2 brd", 1'b0, 32'h13, 32'h0, 2'b00);
    runTxn("t2 hwr", 1'b1, 32'h12, 32'h1234_BEEF, 2'b01);
    runTxn("t2 hwrd", 1'b0, 32'h10, 32'h0, 2'b10);

    runTxn("t3 init", 1'b1, 32'h10, 32'hCAFEBABE, 2'b10);
    runTxn("t3 h12", 1'b0, 32'h12, 32'h0, 2'b01);
    runTxn("t3 h11", 1'b0, 32'h11, 32'h0, 2'b01);
    runTxn("t3 w11", 1'b1, 32'h11, 32'h0BAD_0BAD, 2'b10);
    runTxn("t3 wrd", 1'b0, 32'h10, 32'h0, 2'b10);

    // A request held high is accepted only from IDLE, one response per accept.
    @(negedge clk);
    MEM_req   = 1'b1;
    MEM_write = 1'b0;
    Addr      = 32'h10;
    Size      = 2'b10;
    nReady    = 0;
    firstAt   = -1;
    secondAt  = -1;
    for (int c = 1; c <= 3 * (LATENCY + 3); c++) begin
      @(negedge clk);
      if (MEM_ready) begin
        nReady++;
        if (nReady == 1) firstAt = c;
        else if (nReady == 2) begin
          secondAt = c;
          MEM_req  = 1'b0;
          checkOutput("t4 data", MEM_out, modelMem[4]);
        end
      end
    end
    MEM_req = 1'b0;
    checkOutput("t4 ready count", nReady, 2);
    checkOutput("t4 first ready", firstAt, LATENCY + 2);
    checkOutput("t4 second ready", secondAt, 2 * LATENCY + 5);
    checkOutput("t4 idle after", {31'd0, MEM_busy}, 32'd0);

    // Reset in WAIT, then in ACCESS, must drop the write and the response.
    runTxn("t5 init", 1'b1, 32'h20, 32'h12345678, 2'b10);
    abortAt[0] = 1;
    abortAt[1] = LATENCY + 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      MEM_req   = 1'b1;
      MEM_write = 1'b1;
      Addr      = 32'h20;
      WData     = 32'h55;
      Size      = 2'b10;
      @(posedge clk);
      @(negedge clk);
      MEM_req = 1'b0;
      for (int c = 1; c < abortAt[k]; c++) @(negedge clk);
      checkOutput("t5 busy before reset", {31'd0, MEM_busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("t5 busy after reset", {31'd0, MEM_busy}, 32'd0);
      checkOutput("t5 out after reset", MEM_out, 32'd0);
      nReady = 0;
      for (int c = 0; c < LATENCY + 6; c++) begin
        @(negedge clk);
        if (MEM_ready) nReady++;
      end
      checkOutput("t5 no ready", nReady, 0);
      runTxn("t5 rd", 1'b0, 32'h20, 32'h0, 2'b10);
    end

    runTxn("t6 wr alias", 1'b1, 32'h400, 32'h0A0B0C0D, 2'b10);
    runTxn("t6 rd word0", 1'b0, 32'h0, 32'h0, 2'b10);
    runTxn("t6 size11 rd", 1'b0, 32'h0, 32'h0, 2'b11);
    runTxn("t6 size11 wr", 1'b1, 32'h0, 32'hFFFFFFFF, 2'b11);
    runTxn("t6 rd after", 1'b0, 32'h0, 32'h0, 2'b10);

    $display("[TB] random tests");
    for (int n = 0; n < 80; n++) begin
      logic        wr;
      logic [31:0] a;
      logic [1:0]  sz;
      wr = 1'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      runTxn("rand", wr, a, 32'($urandom), sz);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
